// File: rtl/deserializer.sv
// Receive-side deserializer: gathers PHIT_NUMBER MSB-first phits into one flit,
// strobes it into the receive FIFO, and records flits dropped because the FIFO was full.
module deserializer #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 32,
    parameter int COUNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_SIZE-1:0]  phit_in,
    input  logic                   phit_valid,
    input  logic                   fifo_full,
    input  logic                   clear_overflow,
    output logic [OUTPUT_SIZE-1:0] flit_out,
    output logic                   write_fifo,
    output logic                   deserializer_idle,
    output logic [COUNT_W-1:0]     phit_count,
    output logic                   overflow
);

    localparam int PHIT_NUMBER = OUTPUT_SIZE / INPUT_SIZE;
    localparam logic [COUNT_W-1:0] LAST_PHIT = COUNT_W'(PHIT_NUMBER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVING,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [OUTPUT_SIZE-1:0] shift_q, shift_d;
    logic [OUTPUT_SIZE-1:0] flit_q, flit_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [OUTPUT_SIZE-1:0] shifted;

    assign shifted = {shift_q[OUTPUT_SIZE-INPUT_SIZE-1:0], phit_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            flit_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            flit_q     <= flit_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        flit_d     = flit_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (phit_valid) begin
                    shift_d = {{(OUTPUT_SIZE-INPUT_SIZE){1'b0}}, phit_in};
                    count_d = COUNT_W'(1);
                    state_d = RECEIVING;
                end
            end
            RECEIVING: begin
                if (phit_valid) begin
                    shift_d = shifted;
                    if (count_q == LAST_PHIT) begin
                        flit_d  = shifted;
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // A drop sets the flag even when a clear arrives in the same cycle
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end
                if (phit_valid) begin
                    shift_d = {{(OUTPUT_SIZE-INPUT_SIZE){1'b0}}, phit_in};
                    count_d = COUNT_W'(1);
                    state_d = RECEIVING;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flit_out          = flit_q;
    assign write_fifo        = (state_q == DONE) && !fifo_full;
    assign deserializer_idle = (state_q == IDLE);
    assign phit_count        = count_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer: expected flits are queued as their last
// phit is driven and compared when the DUT strobes write_fifo.
module tb_deserializer;

    logic        clk;
    logic        reset;
    logic [3:0]  phit_in;
    logic        phit_valid;
    logic        fifo_full;
    logic        clear_overflow;
    logic [31:0] flit_out;
    logic        write_fifo;
    logic        deserializer_idle;
    logic [2:0]  phit_count;
    logic        overflow;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;
    int lastWriteCycle = -1;
    int modelCount    = 0;
    logic [31:0] expQueue[$];

    deserializer #(.INPUT_SIZE(4), .OUTPUT_SIZE(32), .COUNT_W(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .phit_in           (phit_in),
        .phit_valid        (phit_valid),
        .fifo_full         (fifo_full),
        .clear_overflow    (clear_overflow),
        .flit_out          (flit_out),
        .write_fifo        (write_fifo),
        .deserializer_idle (deserializer_idle),
        .phit_count        (phit_count),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every write pulse must match the oldest queued flit and respect the minimum spacing
    always @(negedge clk) begin
        if (!reset && write_fifo === 1'b1) begin
            if (lastWriteCycle >= 0)
                checkOutput("wr_spacing", 32'((cycleCount - lastWriteCycle) >= 8), 32'd1);
            lastWriteCycle = cycleCount;
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                checkOutput("flit", flit_out, expQueue.pop_front());
            end
        end
    end

    // One clock of stimulus; the phit counter model is checked after every edge
    task automatic applyStimulus(input logic [3:0] ph, input logic valid);
        phit_in    = ph;
        phit_valid = valid;
        @(posedge clk);
        #1;
        if (valid) modelCount = (modelCount == 7) ? 0 : modelCount + 1;
        checkOutput("phit_count", 32'(phit_count), 32'(modelCount));
    endtask

    task automatic sendFlit(input logic [31:0] data, input logic full, input int gapAt, input int gapLen);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                fifo_full = full;
                if (!full) expQueue.push_back(data);
            end
            applyStimulus(data[31-4*i -: 4], 1'b1);
            checkOutput("busy", 32'(deserializer_idle), 32'd0);
            if (i + 1 == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    applyStimulus(4'h0, 1'b0);
                    checkOutput("gap_count", 32'(phit_count), 32'(gapAt));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        phit_in        = '0;
        phit_valid     = 1'b0;
        fifo_full      = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_count", 32'(phit_count), 32'd0);
        checkOutput("rst_idle", 32'(deserializer_idle), 32'd1);
        checkOutput("rst_write", 32'(write_fifo), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_flit", flit_out, 32'h0);

        $display("[TB] single flit");
        sendFlit(32'hDEADBEEF, 1'b0, -1, 0);
        checkOutput("wr_latency", 32'(write_fifo), 32'd1);
        checkOutput("flit_deadbeef", flit_out, 32'hDEADBEEF);
        applyStimulus(4'h0, 1'b0);
        checkOutput("wr_one_cycle", 32'(write_fifo), 32'd0);
        checkOutput("idle_after", 32'(deserializer_idle), 32'd1);
        checkOutput("flit_hold", flit_out, 32'hDEADBEEF);

        $display("[TB] back-to-back flits");
        sendFlit(32'h12345678, 1'b0, -1, 0);
        checkOutput("b2b_wr1", 32'(write_fifo), 32'd1);
        sendFlit(32'h9ABCDEF0, 1'b0, -1, 0);
        checkOutput("b2b_wr2", 32'(write_fifo), 32'd1);
        applyStimulus(4'h0, 1'b0);

        $display("[TB] gap in phit stream");
        sendFlit(32'hCAFEF00D, 1'b0, 4, 3);
        checkOutput("gap_wr", 32'(write_fifo), 32'd1);
        checkOutput("gap_flit", flit_out, 32'hCAFEF00D);
        applyStimulus(4'h0, 1'b0);

        $display("[TB] overflow handling");
        sendFlit(32'h11111111, 1'b1, -1, 0);
        checkOutput("full_no_wr", 32'(write_fifo), 32'd0);
        applyStimulus(4'h0, 1'b0);
        fifo_full = 1'b0;
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        sendFlit(32'h22222222, 1'b0, -1, 0);
        checkOutput("ovf_next_wr", 32'(write_fifo), 32'd1);
        applyStimulus(4'h0, 1'b0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        applyStimulus(4'h0, 1'b0);
        clear_overflow = 1'b0;
        checkOutput("ovf_clear", 32'(overflow), 32'd0);
        sendFlit(32'h33333333, 1'b1, -1, 0);
        clear_overflow = 1'b1;
        applyStimulus(4'h0, 1'b0);
        clear_overflow = 1'b0;
        fifo_full      = 1'b0;
        checkOutput("ovf_set_wins", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        applyStimulus(4'h0, 1'b0);
        clear_overflow = 1'b0;
        checkOutput("ovf_clear2", 32'(overflow), 32'd0);

        $display("[TB] asynchronous reset mid-flit");
        for (int i = 0; i < 3; i++) applyStimulus(4'hA, 1'b1);
        #2;
        phit_valid = 1'b0;
        reset      = 1'b1;
        modelCount = 0;
        #1;
        checkOutput("arst_count", 32'(phit_count), 32'd0);
        checkOutput("arst_idle", 32'(deserializer_idle), 32'd1);
        checkOutput("arst_write", 32'(write_fifo), 32'd0);
        checkOutput("arst_flit", flit_out, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendFlit(32'h0F0F0F0F, 1'b0, -1, 0);
        checkOutput("arst_wr", 32'(write_fifo), 32'd1);
        checkOutput("arst_flit_clean", flit_out, 32'h0F0F0F0F);
        applyStimulus(4'h0, 1'b0);

        $display("[TB] continuous stream counter");
        sendFlit(32'h55AA55AA, 1'b0, -1, 0);
        applyStimulus(4'h1, 1'b1);
        checkOutput("stream_wrap", 32'(phit_count), 32'd1);
        checkOutput("stream_busy", 32'(deserializer_idle), 32'd0);
        for (int i = 1; i < 8; i++) applyStimulus(4'(i + 1), 1'b1);
        expQueue.push_back(32'h12345678);
        applyStimulus(4'h0, 1'b0);
        applyStimulus(4'h0, 1'b0);
        checkOutput("stream_idle", 32'(deserializer_idle), 32'd1);

        repeat (3) applyStimulus(4'h0, 1'b0);
        checkOutput("queue_empty", 32'(expQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
